// File: rtl/data_memory.sv
// Multi-cycle byte-addressable data memory behind the MA stage.
// Each access stalls the pipeline for LATENCY+1 cycles and performs RV32 load extension.
module data_memory #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  READ,
  input  logic [2:0]  WRITE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic [3:0]        read_q, read_d;
  logic [2:0]        write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       read_data_d;
  logic              misaligned_d;

  logic [31:0]       mem [DEPTH];

  logic              req;
  logic              commit;
  logic              store_v;
  logic              load_v;
  logic              st_mis;
  logic              ld_mis;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [31:0]       word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;
  logic [AW-1:0]     idx;

  // Address bits above the memory size are ignored, so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^ADDR[31:AW+2];

  assign req      = READ[3] | WRITE[2];
  assign BUSYWAIT = ((state_q == StIdle) && req) || (state_q == StBusy);
  assign commit   = (state_q == StBusy) && (cnt_q == '0);
  assign store_v  = write_q[2];
  assign load_v   = read_q[3];
  assign idx      = addr_q[AW+1:2];
  assign word     = mem[idx];
  assign ld_byte  = word[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half  = addr_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    st_mis = 1'b1;
    be     = 4'b1111;
    wlanes = wdata_q;
    case (write_q[1:0])
      2'b00: begin
        st_mis = 1'b0;
        be     = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_mis = addr_q[0];
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      2'b10: st_mis = |addr_q[1:0];
      default: st_mis = 1'b1;
    endcase
  end

  always_comb begin
    ld_mis = 1'b1;
    ld_val = '0;
    case (read_q[2:0])
      3'b000: begin ld_mis = 1'b0;          ld_val = {{24{ld_byte[7]}}, ld_byte};  end
      3'b001: begin ld_mis = addr_q[0];     ld_val = {{16{ld_half[15]}}, ld_half}; end
      3'b010: begin ld_mis = |addr_q[1:0];  ld_val = word;                         end
      3'b100: begin ld_mis = 1'b0;          ld_val = {24'h0, ld_byte};             end
      3'b101: begin ld_mis = addr_q[0];     ld_val = {16'h0, ld_half};             end
      default: begin ld_mis = 1'b1;         ld_val = '0;                           end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    read_d       = read_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    read_data_d  = READ_DATA;
    misaligned_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StBusy;
          cnt_d   = CntW'(LATENCY - 1);
          addr_d  = ADDR[AW+1:0];
          read_d  = READ;
          write_d = WRITE;
          wdata_d = WRITE_DATA;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StDone;
          // A store takes priority; a load issued alongside it returns zero.
          if (store_v) begin
            misaligned_d = st_mis;
            if (load_v) read_data_d = '0;
          end else begin
            misaligned_d = ld_mis;
            read_data_d  = ld_mis ? 32'h0 : ld_val;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      read_q     <= '0;
      write_q    <= '0;
      wdata_q    <= '0;
      READ_DATA  <= '0;
      MISALIGNED <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      READ_DATA  <= read_data_d;
      MISALIGNED <= misaligned_d;
    end
  end

  // Storage is deliberately not reset; reset forces IDLE so no commit can occur.
  always_ff @(posedge CLK) begin
    if (commit && store_v && !st_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed accesses plus random traffic against a byte-array model.
module tb_data_memory;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 4;
  localparam int unsigned NBYTES  = DEPTH * 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDR;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;

  int total  = 0;
  int passed = 0;

  logic [7:0]  mbytes [NBYTES];
  logic [31:0] m_rd;
  logic        m_mis;
  logic [31:0] got_rd;
  logic        got_mis;

  data_memory #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .READ       (READ),
    .WRITE      (WRITE),
    .ADDR       (ADDR),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSYWAIT   (BUSYWAIT),
    .MISALIGNED (MISALIGNED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Reference: memory is a flat byte array; accesses are little-endian byte runs.
  function automatic void model_access(input logic [3:0] rd, input logic [2:0] wr,
                                       input logic [31:0] a, input logic [31:0] wd);
    int unsigned n;
    int unsigned base;
    bit          sgn;
    logic [31:0] v;
    base = a % NBYTES;
    if (wr[2]) begin
      case (wr[1:0])
        2'd0: n = 1;
        2'd1: n = 2;
        2'd2: n = 4;
        default: n = 0;
      endcase
      if (n == 0) m_mis = 1'b1;
      else        m_mis = (base % n) != 0;
      if (!m_mis) for (int k = 0; k < int'(n); k++) mbytes[base + k] = wd[8*k +: 8];
      if (rd[3]) m_rd = 32'h0;
    end else begin
      sgn = 1'b0;
      case (rd[2:0])
        3'd0: begin n = 1; sgn = 1'b1; end
        3'd1: begin n = 2; sgn = 1'b1; end
        3'd2: n = 4;
        3'd4: n = 1;
        3'd5: n = 2;
        default: n = 0;
      endcase
      if (n == 0) m_mis = 1'b1;
      else        m_mis = (base % n) != 0;
      if (m_mis) begin
        m_rd = 32'h0;
      end else begin
        v = 32'h0;
        for (int k = 0; k < int'(n); k++) v = v | ({24'h0, mbytes[base + k]} << (8 * k));
        if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        m_rd = v;
      end
    end
  endfunction

  task automatic access(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] a, input logic [31:0] wd);
    int busy;
    model_access(rd, wr, a, wd);
    @(negedge CLK);
    READ       = rd;
    WRITE      = wr;
    ADDR       = a;
    WRITE_DATA = wd;
    #1;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (!BUSYWAIT) break;
      busy++;
      @(negedge CLK);
      // Scramble address/data while busy; the latched copy must be used.
      ADDR       = $urandom;
      WRITE_DATA = $urandom;
      #1;
    end
    got_rd  = READ_DATA;
    got_mis = MISALIGNED;
    check({tag, ".busy"}, 32'(busy), 32'(LATENCY + 1));
    check({tag, ".rdata"}, got_rd, m_rd);
    check({tag, ".mis"}, {31'h0, got_mis}, {31'h0, m_mis});
    READ  = 4'h0;
    WRITE = 3'h0;
    @(negedge CLK);
    #1;
    check({tag, ".mis_clr"}, {31'h0, MISALIGNED}, 32'h0);
    check({tag, ".idle"}, {31'h0, BUSYWAIT}, 32'h0);
  endtask

  initial begin
    logic [3:0]  rd;
    logic [2:0]  wr;
    int unsigned kind;
    RST        = 1'b0;
    READ       = 4'h0;
    WRITE      = 3'h0;
    ADDR       = 32'h0;
    WRITE_DATA = 32'h0;
    m_rd       = 32'h0;
    m_mis      = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst.rdata", READ_DATA, 32'h0);
    check("rst.mis", {31'h0, MISALIGNED}, 32'h0);
    check("rst.busy", {31'h0, BUSYWAIT}, 32'h0);
    READ = 4'b1010;
    #1;
    check("rst.busy_comb", {31'h0, BUSYWAIT}, 32'h1);
    READ = 4'h0;
    @(negedge CLK);
    RST = 1'b1;

    // Give every word a known value so loads never read undefined storage.
    for (int w = 0; w < int'(DEPTH); w++) access("init", 4'h0, 3'b110, 32'(w * 4), $urandom);

    access("sw_10", 4'h0, 3'b110, 32'h10, 32'hDEAD_BEEF);
    access("lw_10", 4'b1010, 3'h0, 32'h10, 32'h0);
    check("lw_10.lit", got_rd, 32'hDEAD_BEEF);
    access("lb_13", 4'b1000, 3'h0, 32'h13, 32'h0);
    check("lb_13.lit", got_rd, 32'hFFFF_FFDE);
    access("lbu_13", 4'b1100, 3'h0, 32'h13, 32'h0);
    check("lbu_13.lit", got_rd, 32'h0000_00DE);
    access("lh_10", 4'b1001, 3'h0, 32'h10, 32'h0);
    check("lh_10.lit", got_rd, 32'hFFFF_BEEF);
    access("lhu_12", 4'b1101, 3'h0, 32'h12, 32'h0);
    check("lhu_12.lit", got_rd, 32'h0000_DEAD);
    access("sb_11", 4'h0, 3'b100, 32'h11, 32'h0000_0055);
    check("sb_11.hold", got_rd, 32'h0000_DEAD);
    access("lw_10b", 4'b1010, 3'h0, 32'h10, 32'h0);
    check("lw_10b.lit", got_rd, 32'hDEAD_55EF);
    access("lw_12mis", 4'b1010, 3'h0, 32'h12, 32'h0);
    check("lw_12mis.lit", got_rd, 32'h0);
    check("lw_12mis.flag", {31'h0, got_mis}, 32'h1);
    access("sh_11mis", 4'h0, 3'b101, 32'h11, 32'h0000_FFFF);
    check("sh_11mis.flag", {31'h0, got_mis}, 32'h1);
    access("lw_10c", 4'b1010, 3'h0, 32'h10, 32'h0);
    check("lw_10c.lit", got_rd, 32'hDEAD_55EF);
    access("sw_400", 4'h0, 3'b110, 32'h400, 32'h1234_5678);
    access("lw_000", 4'b1010, 3'h0, 32'h000, 32'h0);
    check("lw_000.lit", got_rd, 32'h1234_5678);
    access("ld_st", 4'b1010, 3'b110, 32'h30, 32'hCAFE_F00D);
    check("ld_st.lit", got_rd, 32'h0);

    // Reset in the middle of a store: nothing committed, outputs cleared.
    access("sw_20", 4'h0, 3'b110, 32'h20, 32'h0);
    access("lw_10d", 4'b1010, 3'h0, 32'h10, 32'h0);
    @(negedge CLK);
    WRITE      = 3'b110;
    ADDR       = 32'h20;
    WRITE_DATA = 32'hAAAA_AAAA;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    WRITE = 3'h0;
    RST   = 1'b0;
    #1;
    check("rstmid.busy", {31'h0, BUSYWAIT}, 32'h0);
    check("rstmid.rdata", READ_DATA, 32'h0);
    check("rstmid.mis", {31'h0, MISALIGNED}, 32'h0);
    m_rd  = 32'h0;
    m_mis = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    access("lw_20", 4'b1010, 3'h0, 32'h20, 32'h0);
    check("lw_20.lit", got_rd, 32'h0);

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 2);
      rd   = {kind != 1, 3'($urandom)};
      wr   = {kind != 0, 2'($urandom)};
      access("rand", rd, wr, $urandom & 32'hFFFF_F03F, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Multi-cycle data memory that sits directly downstream of the CPU's memory-access (MA) stage. It consumes the MA-stage address, write data and load/store controls, and returns load data to the MA/WB pipeline register. It performs byte, halfword and word accesses with RV32 sign/zero extension. It holds the pipeline via `BUSYWAIT` for a fixed, parameterised latency.

## Interface
Parameters:
- `DEPTH`, default 256: number of 32-bit words; power of two.
- `LATENCY`, default 4: cycles spent in BUSY per access; ≥1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `READ` in 4: load control. Bit 3 means load valid. Bits [2:0] are funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `WRITE` in 3: store control. Bit 2 means store valid. Bits [1:0] are size: 00 SB, 01 SH, 10 SW.
- `ADDR` in 32: byte address.
- `WRITE_DATA` in 32: store data; lanes taken from its low bits.
- `READ_DATA` out 32: extended load result, registered.
- `BUSYWAIT` out 1: stall request to every pipeline register and the PC.
- `MISALIGNED` out 1: the completing access was misaligned.

## Operation
- Word index is `ADDR[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH·4.
- States:
  - IDLE: no access in flight.
  - BUSY: down-counter `cnt` running.
  - DONE: access completed; result presented for one cycle.
- Transitions:
  - IDLE → BUSY when `READ[3]|WRITE[2]`. Load `cnt=LATENCY-1` and latch address, controls and write data.
  - BUSY with `cnt≠0`: decrement `cnt`.
  - BUSY with `cnt==0`: commit the access, then go to DONE.
  - DONE → IDLE unconditionally.
- Inputs are latched at IDLE→BUSY. Input changes during BUSY have no effect.
- `BUSYWAIT` is asserted in these cases:
  - Combinationally in IDLE when a request is present.
  - Throughout BUSY.
  - It is low in DONE and in IDLE with no request.
- Store commit writes byte lanes only:
  - SB writes lane `ADDR[1:0]`.
  - SH writes lanes {1,0} or {3,2} selected by `ADDR[1]`.
  - SW writes all 4 lanes.
  - Unselected lanes are unchanged.
- Load commit:
  - Selects the byte or halfword by `ADDR[1:0]`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - The result is registered into `READ_DATA`.
- Misalignment rules:
  - LH/LHU/SH with `ADDR[0]=1` is misaligned.
  - LW/SW with `ADDR[1:0]≠0` is misaligned.
  - A misaligned store leaves memory unchanged.
  - A misaligned load sets `READ_DATA=0`.
  - `MISALIGNED=1` in the DONE cycle only.
- Illegal combinations:
  - Reserved READ funct3 (011, 110, 111) or WRITE size 11 is treated as misaligned, with the same handling.
  - A simultaneous load and store: the store wins and `READ_DATA` is set to 0.
- `READ_DATA` holds its value until the next load commits. Stores do not alter it.
- Memory contents are not cleared by reset; the initial contents are undefined.

## Timing
- Reset values:
  - FSM = IDLE, `cnt=0`.
  - `READ_DATA=0`, `MISALIGNED=0`.
  - `BUSYWAIT` follows the IDLE rule, i.e. it is combinational on inputs.
- Request seen in cycle 0 (IDLE):
  - BUSY spans cycles 1..LATENCY.
  - DONE is cycle LATENCY+1.
  - `BUSYWAIT` is high for LATENCY+1 cycles, 0..LATENCY.
- The load result is valid on `READ_DATA` in the DONE cycle. The MA/WB register captures it at the end of that cycle.
- Back-to-back accesses:
  - The pipeline advances at the end of DONE.
  - The next request is seen in IDLE on the following cycle.
  - The minimum spacing between request starts is LATENCY+2 cycles.
  - A request is never serviced twice.
- Reset asserted mid-BUSY:
  - Immediately go to IDLE.
  - The pending store is not committed.
  - `READ_DATA` and `MISALIGNED` are cleared.
- Read-after-write to the same address in consecutive accesses returns the new data.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x10 followed by LW 0x10.
  - `BUSYWAIT` is high for 5 cycles per access (LATENCY=4).
  - `READ_DATA`=0xDEADBEEF in the DONE cycle.
- Byte loads after the SW above:
  - LB at 0x13 returns 0xFFFFFFDE; LBU at 0x13 returns 0x000000DE.
  - LH at 0x10 returns 0xFFFFBEEF; LHU at 0x12 returns 0x0000DEAD.
- Byte store: SB 0x55 to 0x11, then LW 0x10 → 0xDEAD55EF. The other lanes are intact.
- Misaligned accesses:
  - LW at 0x12 gives `READ_DATA`=0 and `MISALIGNED`=1 for one cycle.
  - SH at 0x11 followed by LW 0x10 returns unchanged data.
- Wrap-around: with DEPTH=256, SW 0x12345678 to 0x400, then LW 0x000 → 0x12345678.
- Reset mid-operation:
  - Start SW 0xAAAAAAAA to 0x20 over prior data 0x0, and pulse `RST` low in BUSY cycle 2.
  - `BUSYWAIT` drops at once and the FSM returns to IDLE.
  - A subsequent LW 0x20 returns 0x0.
